// File: rtl/mau_multi_pkg.sv
// Shared definitions for the memory access unit: FSM states, target codes
// and the data returned on an error completion.
package mau_multi_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_t;

   typedef enum logic [1:0] {
      TGT_MEM,
      TGT_PER,
      TGT_UNMAP
   } tgt_t;

   localparam logic [63:0] ERR_DATA = '0;

endpackage

// File: rtl/mau_multi_prims.sv
// Small shared primitives: a rising-edge pulse generator and a tri-state
// bus driver.
module spulse (
   input  logic clk,
   input  logic arst_n,
   input  logic d,
   output logic q
);

   logic d_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) d_q <= 1'b0;
      else         d_q <= d;
   end

   assign q = d & ~d_q;

endmodule

module tsb_h #(
   parameter int W = 16
) (
   input  logic         en,
   input  logic [W-1:0] d,
   inout  logic [W-1:0] y
);

   assign y = en ? d : 'z;

endmodule

// File: rtl/mau_multi.sv
// Memory access unit: MAR/MDR pair on a shared CPU bus, dispatching each
// access to memory or one of NPER peripheral channels with a timeout.
module mau_multi
   import mau_multi_pkg::*;
#(
   parameter int          DW       = 16,
   parameter int          AW       = 16,
   parameter logic [31:0] PER_BASE = 16'hFE00,
   parameter int          NPER     = 4,
   parameter int          PER_SPAN = 64,
   parameter int          TO_CYC   = 255
) (
   input  logic                clk,
   input  logic                arst_n,
   inout  logic [DW-1:0]       bus,
   input  logic                cpu_ld_mdr,
   input  logic                cpu_ld_mar,
   input  logic                cpu_gate_mdr,
   input  logic                cpu_mio_en,
   input  logic                cpu_rw,
   output logic                cpu_rdy,
   output logic                cpu_berr,
   output logic                mem_init_txn,
   output logic                mem_wtxn,
   output logic [AW-1:0]       mem_addr,
   output logic [DW-1:0]       mem_wdata,
   input  logic [DW-1:0]       mem_rdata,
   input  logic                mem_rdy,
   output logic [NPER-1:0]     per_init_txn,
   output logic                per_wtxn,
   output logic [7:0]          per_addr,
   output logic [DW-1:0]       per_wdata,
   input  logic [NPER*DW-1:0]  per_rdata,
   input  logic [NPER-1:0]     per_rdy
);

   localparam int SW  = $clog2(PER_SPAN);
   localparam int CHW = (NPER > 1) ? $clog2(NPER) : 1;
   localparam int CW  = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;

   state_t          state, state_d;
   logic [AW-1:0]   mar, addr_q;
   logic [DW-1:0]   mdr, rd_mux, sel_data;
   tgt_t            tgt_d, tgt_q;
   logic [CHW-1:0]  ch_d, ch_q;
   logic [AW-1:0]   off, k_full;
   logic [7:0]      woff, woff_q;
   logic [CW-1:0]   cnt;
   logic            rw_q, first_q, err_q;
   logic            mio_rise, start, busy, sel_rdy, to_hit, done, err_now;

   spulse u_edge (
      .clk    (clk),
      .arst_n (arst_n),
      .d      (cpu_mio_en),
      .q      (mio_rise)
   );

   tsb_h #(.W(DW)) u_drv (
      .en (cpu_gate_mdr),
      .d  (mdr),
      .y  (bus)
   );

   always_comb begin
      off    = mar - AW'(PER_BASE);
      k_full = off >> SW;
      woff   = 8'((off & AW'(PER_SPAN - 1)) >> 1);
      ch_d   = CHW'(k_full);
      if (mar < AW'(PER_BASE))       tgt_d = TGT_MEM;
      else if (k_full < AW'(NPER))   tgt_d = TGT_PER;
      else                           tgt_d = TGT_UNMAP;
   end

   // Everything below works from the copies taken at start, never from MAR.
   always_comb begin
      sel_rdy  = 1'b0;
      sel_data = ERR_DATA[DW-1:0];
      case (tgt_q)
         TGT_MEM: begin
            sel_rdy  = mem_rdy;
            sel_data = mem_rdata;
         end
         TGT_PER: begin
            sel_rdy  = per_rdy[ch_q];
            sel_data = per_rdata[int'(ch_q)*DW +: DW];
         end
         default: ;
      endcase
   end

   assign busy    = (state == ST_BUSY);
   assign start   = mio_rise && (state == ST_IDLE);
   assign to_hit  = (TO_CYC != 0) && (cnt == CW'(TO_CYC));
   assign done    = busy && (sel_rdy || (tgt_q == TGT_UNMAP) || to_hit);
   assign err_now = busy && !sel_rdy && ((tgt_q == TGT_UNMAP) || to_hit);
   assign rd_mux  = (err_now || err_q) ? ERR_DATA[DW-1:0] : sel_data;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state <= ST_IDLE;
      else         state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE: if (start) state_d = ST_BUSY;
         ST_BUSY: if (done)  state_d = ST_IDLE;
         default:            state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_init_txn = 1'b0;
      per_init_txn = '0;
      if (busy && first_q) begin
         if (tgt_q == TGT_MEM) mem_init_txn = 1'b1;
         if (tgt_q == TGT_PER) per_init_txn = NPER'(1) << ch_q;
      end
      cpu_rdy  = done;
      cpu_berr = err_now;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         mar     <= '0;
         mdr     <= '0;
         addr_q  <= '0;
         woff_q  <= '0;
         tgt_q   <= TGT_MEM;
         ch_q    <= '0;
         rw_q    <= 1'b0;
         cnt     <= '0;
         first_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (cpu_ld_mar) mar <= AW'(bus);
         if (cpu_ld_mdr) mdr <= cpu_mio_en ? rd_mux : bus;
         if (start) begin
            tgt_q   <= tgt_d;
            ch_q    <= ch_d;
            rw_q    <= cpu_rw;
            addr_q  <= mar;
            woff_q  <= woff;
            cnt     <= '0;
            first_q <= 1'b1;
            err_q   <= 1'b0;
         end else begin
            first_q <= 1'b0;
            if (busy && cnt != '1) cnt <= cnt + CW'(1);
            if (done) err_q <= err_now;
         end
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wtxn  = rw_q;
   assign mem_wdata = mdr;
   assign per_addr  = woff_q;
   assign per_wtxn  = rw_q;
   assign per_wdata = mdr;

endmodule
